// File: rtl/raycast_pkg.sv
// Shared raycaster constants and the column scheduler state type.
package raycast_pkg;

    // Frame geometry: 160 columns x 0.375 deg = 60 deg field of view
    localparam int unsigned NUM_COLS       = 160;
    localparam int unsigned COL_W          = 8;
    localparam int unsigned HALF_FOV_DEG   = 30;
    localparam int unsigned RAY_STEP_MILLI = 375;

    // Pose and result field widths
    localparam int unsigned POS_W   = 13;
    localparam int unsigned ANG_W   = 10;
    localparam int unsigned SLICE_W = 7;

    // Watchdog defaults
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned TO_W    = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_CALC = 3'd3,
        S_EMIT      = 3'd4,
        S_DONE      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/scheduler_watchdog.sv
// Per-column watchdog: counts wait cycles, flags expiry at TIMEOUT.
module scheduler_watchdog
    import raycast_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count;

    // Counter: clear wins, then saturating increment while enabled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry flag straight off the counter value
    always_comb begin
        expired = (count == LIMIT);
    end

endmodule

// File: rtl/slice_column_scheduler.sv
// Frame sequencer for the per-column slice-size engine: snapshots pose,
// issues one calculation per column, hands each result to the renderer.
module slice_column_scheduler #(
    parameter int unsigned NUM_COLS = raycast_pkg::NUM_COLS,
    parameter int unsigned COL_W    = raycast_pkg::COL_W,
    parameter int unsigned TIMEOUT  = raycast_pkg::TIMEOUT,
    parameter int unsigned TO_W     = raycast_pkg::TO_W
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              start_frame,
    input  logic [raycast_pkg::POS_W-1:0]     playerX_in,
    input  logic [raycast_pkg::POS_W-1:0]     playerY_in,
    input  logic [raycast_pkg::ANG_W-1:0]     angle_X_in,
    input  logic [raycast_pkg::ANG_W-1:0]     angle_Y_in,
    output logic [raycast_pkg::POS_W-1:0]     playerX,
    output logic [raycast_pkg::POS_W-1:0]     playerY,
    output logic [raycast_pkg::ANG_W-1:0]     angle_X,
    output logic [raycast_pkg::ANG_W-1:0]     angle_Y,
    output logic [COL_W-1:0]                  column_count,
    output logic                              begin_calc,
    input  logic                              end_calc,
    input  logic [raycast_pkg::SLICE_W-1:0]   slice_size,
    output logic                              col_valid,
    input  logic                              col_ready,
    output logic [COL_W-1:0]                  col_index,
    output logic [raycast_pkg::SLICE_W-1:0]   col_size,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              timeout_err
);

    import raycast_pkg::*;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    sched_state_t state;
    logic         wd_clear;
    logic         wd_enable;
    logic         wd_expired;

    // Watchdog is zeroed while a column is being issued and runs only while waiting
    always_comb begin
        wd_clear  = (state == S_ISSUE);
        wd_enable = (state == S_WAIT_CALC);
    end

    scheduler_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Frame FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            playerX      <= '0;
            playerY      <= '0;
            angle_X      <= '0;
            angle_Y      <= '0;
            column_count <= '0;
            begin_calc   <= 1'b0;
            col_valid    <= 1'b0;
            col_index    <= '0;
            col_size     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            begin_calc <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    playerX      <= playerX_in;
                    playerY      <= playerY_in;
                    angle_X      <= angle_X_in;
                    angle_Y      <= angle_Y_in;
                    column_count <= '0;
                    begin_calc   <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_WAIT_CALC;
                end
                S_WAIT_CALC: begin
                    // A result arriving on the expiry cycle still counts as success
                    if (end_calc) begin
                        col_size  <= slice_size;
                        col_index <= column_count;
                        col_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        col_size    <= '0;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_EMIT: begin
                    if (col_ready) begin
                        col_valid <= 1'b0;
                        if (column_count == LAST_COL) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            column_count <= column_count + 1'b1;
                            begin_calc   <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_column_scheduler.sv
// Self-checking bench for slice_column_scheduler (4 columns, TIMEOUT=15).
module tb_slice_column_scheduler;

    localparam int unsigned T_COLS    = 4;
    localparam int unsigned T_TIMEOUT = 15;
    localparam int          BP_CYCLES = 20;
    localparam int          NV        = 7;

    logic        clock;
    logic        resetn;
    logic        start_frame;
    logic [12:0] playerX_in, playerY_in;
    logic [9:0]  angle_X_in, angle_Y_in;
    logic [12:0] playerX, playerY;
    logic [9:0]  angle_X, angle_Y;
    logic [7:0]  column_count;
    logic        begin_calc;
    logic        end_calc;
    logic [6:0]  slice_size;
    logic        col_valid;
    logic        col_ready;
    logic [7:0]  col_index;
    logic [6:0]  col_size;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    slice_column_scheduler #(
        .NUM_COLS (T_COLS),
        .COL_W    (8),
        .TIMEOUT  (T_TIMEOUT),
        .TO_W     (4)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start_frame  (start_frame),
        .playerX_in   (playerX_in),
        .playerY_in   (playerY_in),
        .angle_X_in   (angle_X_in),
        .angle_Y_in   (angle_Y_in),
        .playerX      (playerX),
        .playerY      (playerY),
        .angle_X      (angle_X),
        .angle_Y      (angle_Y),
        .column_count (column_count),
        .begin_calc   (begin_calc),
        .end_calc     (end_calc),
        .slice_size   (slice_size),
        .col_valid    (col_valid),
        .col_ready    (col_ready),
        .col_index    (col_index),
        .col_size     (col_size),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [12:0] px;
        logic [12:0] py;
        logic [9:0]  ax;
        logic [9:0]  ay;
        int          lat;
        int          hang;
        bit          spur;
        int          bp_col;
        bit          done_start;
        int          exp_begins;
        int          exp_cols;
        int          exp_lat;
        bit          exp_to;
    } frame_vec_t;

    typedef struct {
        logic [7:0] col;
        logic [6:0] size;
    } sb_item_t;

    sb_item_t   sb[$];
    frame_vec_t vecs[NV];

    int compared   = 0;
    int mismatched = 0;

    // engine model configuration (written by the main process only)
    int eng_lat   = 12;
    int hang_col  = -1;
    bit spur_mode = 1'b0;

    // monitor state
    int         cyc = 0;
    int         last_begin_cyc = 0;
    int         exp_next_col = 0;
    int         cur_cols = 0;
    int         n_begins = 0;
    int         n_accepts = 0;
    int         n_dones = 0;
    int         bp_col = -1;
    int         bp_cnt = 0;
    logic [6:0] bp_size = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: end_calc eng_lat cycles after begin_calc, size = column + 10
    initial begin : engine
        int         eng_left;
        bit         eng_busy;
        bit         eng_hang;
        logic [6:0] eng_size;
        eng_left = 0;
        eng_busy = 1'b0;
        eng_hang = 1'b0;
        eng_size = '0;
        end_calc = 1'b0;
        slice_size = '0;
        forever begin
            @(posedge clock);
            #1;
            end_calc = 1'b0;
            if (!resetn) begin
                eng_busy = 1'b0;
            end else begin
                if (eng_busy) begin
                    eng_left--;
                    if (eng_left == 0) begin
                        eng_busy = 1'b0;
                        if (!eng_hang) begin
                            end_calc   = 1'b1;
                            slice_size = eng_size;
                        end
                    end
                end
                if (spur_mode && !end_calc && (begin_calc || col_valid)) begin
                    end_calc   = 1'b1;
                    slice_size = 7'h7F;
                end
                if (begin_calc) begin
                    eng_busy = 1'b1;
                    eng_left = eng_lat;
                    eng_size = 7'(column_count + 8'd10);
                    eng_hang = (int'(column_count) == hang_col);
                end
            end
        end
    end

    // One cycle: wait for the falling edge, drive back-pressure, then monitor outputs
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (bp_col >= 0) begin
            if (bp_cnt == 0 && col_valid && int'(col_index) == bp_col) begin
                bp_size   = col_size;
                bp_cnt    = 1;
                col_ready = 1'b0;
            end else if (bp_cnt > 0 && bp_cnt <= BP_CYCLES) begin
                chk("bp_valid", 32'(col_valid), 32'd1);
                chk("bp_index", 32'(col_index), 32'(bp_col));
                chk("bp_size", 32'(col_size), 32'(bp_size));
                chk("bp_no_begin", 32'(begin_calc), 32'd0);
                col_ready = (bp_cnt < BP_CYCLES) ? 1'b0 : 1'b1;
                bp_cnt++;
            end else begin
                col_ready = 1'b1;
            end
        end
        if (begin_calc) begin
            chk("issue_col", 32'(column_count), 32'(exp_next_col));
            if (exp_next_col < cur_cols)
                sb.push_back('{col: 8'(exp_next_col), size: 7'(exp_next_col + 10)});
            exp_next_col++;
            n_begins++;
            last_begin_cyc = cyc;
        end
        if (col_valid) begin
            chk("no_begin_while_valid", 32'(begin_calc), 32'd0);
            if (col_ready) begin
                chk("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    sb_item_t it;
                    it = sb.pop_front();
                    chk("out_index", 32'(col_index), 32'(it.col));
                    chk("out_size", 32'(col_size), 32'(it.size));
                end
                n_accepts++;
            end
        end
        if (frame_done) n_dones++;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int edges;
        bit done_seen;
        eng_lat      = v.lat;
        hang_col     = v.hang;
        spur_mode    = v.spur;
        bp_col       = v.bp_col;
        bp_cnt       = 0;
        cur_cols     = v.exp_cols;
        exp_next_col = 0;
        sb.delete();
        n_begins  = 0;
        n_accepts = 0;
        n_dones   = 0;
        col_ready = 1'b1;
        playerX_in = v.px;
        playerY_in = v.py;
        angle_X_in = v.ax;
        angle_Y_in = v.ay;
        start_frame = 1'b1;
        edges = 0;
        done_seen = 1'b0;
        while (!done_seen && edges < 3000) begin
            tick();
            edges++;
            if (edges == 1) begin
                start_frame = 1'b0;
                chk("accept_busy", 32'(busy), 32'd1);
                chk("accept_clears_timeout", 32'(timeout_err), 32'd0);
            end
            if (edges >= 2) begin
                playerX_in = 13'($urandom);
                playerY_in = 13'($urandom);
                angle_X_in = 10'($urandom);
                angle_Y_in = 10'($urandom);
            end
            if (edges == 10) start_frame = 1'b1;
            if (edges == 11) start_frame = 1'b0;
            if (frame_done) done_seen = 1'b1;
        end
        chk("frame_done_seen", 32'(done_seen), 32'd1);
        chk("frame_latency", 32'(edges + 1), 32'(v.exp_lat));
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_timeout_err", 32'(timeout_err), 32'(v.exp_to));
        chk("begin_count", 32'(n_begins), 32'(v.exp_begins));
        chk("accept_count", 32'(n_accepts), 32'(v.exp_cols));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("snap_playerX", 32'(playerX), 32'(v.px));
        chk("snap_playerY", 32'(playerY), 32'(v.py));
        chk("snap_angle_X", 32'(angle_X), 32'(v.ax));
        chk("snap_angle_Y", 32'(angle_Y), 32'(v.ay));
        if (v.done_start) start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        chk("post_done_idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("post_done_still_idle", 32'(busy), 32'd0);
        chk("frame_done_count", 32'(n_dones), 32'd1);
        chk("timeout_sticky", 32'(timeout_err), 32'(v.exp_to));
        bp_col = -1;
        spur_mode = 1'b0;
    endtask

    // Assert reset asynchronously at a chosen point of a running frame
    task automatic reset_mid(input int mode);
        int waited;
        bit hit;
        eng_lat = 12;
        hang_col = -1;
        spur_mode = 1'b0;
        bp_col = -1;
        cur_cols = T_COLS;
        exp_next_col = 0;
        sb.delete();
        n_begins = 0;
        col_ready = 1'b1;
        playerX_in = 13'd321;
        playerY_in = 13'd654;
        angle_X_in = 10'd12;
        angle_Y_in = 10'd500;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        hit = 1'b0;
        waited = 0;
        while (!hit && waited < 200) begin
            tick();
            waited++;
            case (mode)
                0:       hit = (n_begins == 2) && (cyc == last_begin_cyc + 3);
                1:       hit = (n_begins == 2) && begin_calc;
                default: hit = col_valid;
            endcase
        end
        chk("rst_point_reached", 32'(hit), 32'd1);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_valid", 32'(col_valid), 32'd0);
        chk("rst_async_begin", 32'(begin_calc), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        sb.delete();
        exp_next_col = 0;
        tick();
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_column_count", 32'(column_count), 32'd0);
        chk("rst_snapshot", 32'(playerX), 32'd0);
        chk("rst_col_size", 32'(col_size), 32'd0);
        chk("rst_col_index", 32'(col_index), 32'd0);
    endtask

    initial begin : watchdog_guard
        #3000000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        vecs[0] = '{px: 13'd100,   py: 13'h1F38, ax: 10'd45,   ay: 10'd375, lat: 12, hang: -1, spur: 0,
                    bp_col: -1, done_start: 0, exp_begins: 4, exp_cols: 4, exp_lat: 59, exp_to: 0};
        vecs[1] = '{px: 13'h0FFF,  py: 13'h1000, ax: 10'h200,  ay: 10'd999, lat: 3,  hang: -1, spur: 0,
                    bp_col: 1,  done_start: 0, exp_begins: 4, exp_cols: 4, exp_lat: 43, exp_to: 0};
        vecs[2] = '{px: 13'd1,     py: 13'd2,    ax: 10'd3,    ay: 10'd4,   lat: 16, hang: -1, spur: 0,
                    bp_col: -1, done_start: 0, exp_begins: 4, exp_cols: 4, exp_lat: 75, exp_to: 0};
        vecs[3] = '{px: 13'h1FFF,  py: 13'd0,    ax: 10'h3FF,  ay: 10'd0,   lat: 12, hang: 2,  spur: 0,
                    bp_col: -1, done_start: 1, exp_begins: 3, exp_cols: 2, exp_lat: 48, exp_to: 1};
        vecs[4] = '{px: 13'd77,    py: 13'd88,   ax: 10'd99,   ay: 10'd111, lat: 17, hang: -1, spur: 0,
                    bp_col: -1, done_start: 0, exp_begins: 1, exp_cols: 0, exp_lat: 20, exp_to: 1};
        vecs[5] = '{px: 13'h1555,  py: 13'h0AAA, ax: 10'h155,  ay: 10'h2AA, lat: 5,  hang: -1, spur: 1,
                    bp_col: -1, done_start: 0, exp_begins: 4, exp_cols: 4, exp_lat: 31, exp_to: 0};
        vecs[6] = '{px: 13'd4000,  py: 13'h1F00, ax: 10'd7,    ay: 10'd1,   lat: 2,  hang: -1, spur: 0,
                    bp_col: -1, done_start: 1, exp_begins: 4, exp_cols: 4, exp_lat: 19, exp_to: 0};

        resetn = 1'b0;
        start_frame = 1'b0;
        col_ready = 1'b1;
        playerX_in = 13'd555;
        playerY_in = 13'd666;
        angle_X_in = 10'd77;
        angle_Y_in = 10'd88;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_begin", 32'(begin_calc), 32'd0);
        chk("reset_valid", 32'(col_valid), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        chk("reset_timeout", 32'(timeout_err), 32'd0);
        chk("reset_column", 32'(column_count), 32'd0);
        chk("reset_snapshot", 32'({playerX, playerY, angle_X[5:0]}), 32'd0);
        chk("reset_result", 32'({col_index, col_size}), 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        chk("idle_no_start", 32'(busy), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_frame(vecs[i]);
        end

        reset_mid(0);
        reset_mid(1);
        reset_mid(2);
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
